// File: rtl/cache_refill_ctrl_if.sv
// Handshake and array-write bundle for the cache refill controller: the
// miss request, the AXI4 read address/data channels, the data array word
// write port, the tag store write port and the completion status.
interface cache_refill_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 19,
  parameter int INDEX_W = 7
);
  logic               miss_valid;
  logic               miss_ready;
  logic [ADDR_W-1:0]  miss_addr;

  logic               arvalid;
  logic               arready;
  logic [ADDR_W-1:0]  araddr;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;

  logic               rvalid;
  logic               rready;
  logic [DATA_W-1:0]  rdata;
  logic [1:0]         rresp;
  logic               rlast;

  logic               data_we;
  logic [INDEX_W-1:0] data_index;
  logic [1:0]         data_way;
  logic [3:0]         data_word;
  logic [DATA_W-1:0]  data_wdata;

  logic               tag_we;
  logic [INDEX_W-1:0] tag_index;
  logic [1:0]         tag_way;
  logic [TAG_W-1:0]   tag_new;

  logic               fill_done;
  logic               fill_err;

  // Controller side
  modport master (
    input  miss_valid, miss_addr,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output miss_ready,
    output arvalid, araddr, arlen, arsize, arburst,
    output rready,
    output data_we, data_index, data_way, data_word, data_wdata,
    output tag_we, tag_index, tag_way, tag_new,
    output fill_done, fill_err
  );

  // Miss detector / AXI slave / arrays side
  modport slave (
    output miss_valid, miss_addr,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  miss_ready,
    input  arvalid, araddr, arlen, arsize, arburst,
    input  rready,
    input  data_we, data_index, data_way, data_word, data_wdata,
    input  tag_we, tag_index, tag_way, tag_new,
    input  fill_done, fill_err
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache refill controller. Accepts one miss at a time, picks the victim way
// from a per-set round-robin counter, fetches the 64-byte line with a single
// 16-beat AXI4 INCR burst, writes each beat straight into the data array and,
// only when the burst was clean, writes the new tag and advances the set's
// round-robin counter.
module cache_refill_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 19,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_refill_ctrl_if.master bus
);

  localparam int BEATS = (1 << OFFSET_W) / (DATA_W / 8);
  localparam int SETS  = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_AR     = 2'd1,
    S_RDATA  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [TAG_W-1:0]   r_tag;
  logic [INDEX_W-1:0] r_index;
  logic [1:0]         r_way;
  logic [3:0]         r_beat;
  logic               r_err;
  logic [1:0]         r_rr [SETS];

  logic [TAG_W-1:0]   w_miss_tag;
  logic [INDEX_W-1:0] w_miss_index;
  logic               w_accept;
  logic               w_beat_fire;
  logic               w_last_count;
  logic               w_burst_end;
  logic               w_clean_end;
  logic               w_resp_err;
  logic               w_unused_offset;

  assign w_miss_tag      = bus.miss_addr[ADDR_W-1 -: TAG_W];
  assign w_miss_index    = bus.miss_addr[OFFSET_W +: INDEX_W];
  assign w_unused_offset = ^bus.miss_addr[OFFSET_W-1:0];

  assign w_accept     = (r_state == S_IDLE) && bus.miss_valid;
  assign w_beat_fire  = (r_state == S_RDATA) && bus.rvalid;
  assign w_last_count = (r_beat == 4'(BEATS - 1));
  // The burst stops at whichever comes first: the slave's rlast or our 16th beat.
  assign w_burst_end  = bus.rlast || w_last_count;
  // Only a burst whose rlast lands exactly on the 16th beat is well formed.
  assign w_clean_end  = bus.rlast && w_last_count;
  assign w_resp_err   = (bus.rresp != 2'b00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.miss_valid) w_next = S_AR;
      S_AR:     if (bus.arready)    w_next = S_RDATA;
      S_RDATA:  if (w_beat_fire && w_burst_end) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Capture the request, count beats and accumulate the sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag   <= '0;
      r_index <= '0;
      r_way   <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tag   <= w_miss_tag;
        r_index <= w_miss_index;
        r_way   <= r_rr[w_miss_index];
      end
      if (w_beat_fire) begin
        r_beat <= r_beat + 4'd1;
        r_err  <= r_err | w_resp_err | (w_burst_end & ~w_clean_end);
      end
      if (r_state == S_COMMIT) begin
        r_beat <= '0;
        r_err  <= 1'b0;
      end
    end
  end

  // Per-set round-robin victim counters; only a clean fill advances its set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) r_rr[i] <= 2'd0;
    end else if ((r_state == S_COMMIT) && !r_err) begin
      r_rr[r_index] <= r_rr[r_index] + 2'd1;
    end
  end

  assign bus.miss_ready = (r_state == S_IDLE);

  assign bus.arvalid = (r_state == S_AR);
  assign bus.araddr  = {r_tag, r_index, {OFFSET_W{1'b0}}};
  assign bus.arlen   = 8'(BEATS - 1);
  assign bus.arsize  = 3'($clog2(DATA_W / 8));
  assign bus.arburst = 2'b01;

  assign bus.rready  = (r_state == S_RDATA);

  assign bus.data_we    = w_beat_fire;
  assign bus.data_index = r_index;
  assign bus.data_way   = r_way;
  assign bus.data_word  = r_beat;
  assign bus.data_wdata = bus.rdata;

  assign bus.tag_we    = (r_state == S_COMMIT) && !r_err;
  assign bus.tag_index = r_index;
  assign bus.tag_way   = r_way;
  assign bus.tag_new   = r_tag;

  assign bus.fill_done = (r_state == S_COMMIT);
  assign bus.fill_err  = (r_state == S_COMMIT) && r_err;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl: drives misses and an AXI read
// slave, and compares every observable against a per-set victim model.
module tb_cache_refill_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  int rr_model [128];

  always #5 clk = ~clk;

  cache_refill_ctrl_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(19), .INDEX_W(7)) bus ();

  cache_refill_ctrl #(
    .ADDR_W(32), .DATA_W(32), .TAG_W(19), .INDEX_W(7), .OFFSET_W(6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_miss_ready"}, 64'(bus.miss_ready), 64'd1);
    chk({pfx, "_arvalid"},    64'(bus.arvalid),    64'd0);
    chk({pfx, "_araddr"},     64'(bus.araddr),     64'd0);
    chk({pfx, "_rready"},     64'(bus.rready),     64'd0);
    chk({pfx, "_data_we"},    64'(bus.data_we),    64'd0);
    chk({pfx, "_data_index"}, 64'(bus.data_index), 64'd0);
    chk({pfx, "_data_way"},   64'(bus.data_way),   64'd0);
    chk({pfx, "_data_word"},  64'(bus.data_word),  64'd0);
    chk({pfx, "_tag_we"},     64'(bus.tag_we),     64'd0);
    chk({pfx, "_tag_index"},  64'(bus.tag_index),  64'd0);
    chk({pfx, "_tag_way"},    64'(bus.tag_way),    64'd0);
    chk({pfx, "_tag_new"},    64'(bus.tag_new),    64'd0);
    chk({pfx, "_fill_done"},  64'(bus.fill_done),  64'd0);
    chk({pfx, "_fill_err"},   64'(bus.fill_err),   64'd0);
  endtask

  // One refill as seen from the outside. err_beat: 0-based beat carrying
  // SLVERR (-1 none). rlast_beat: 1-based beat carrying rlast (0 none).
  // rst_beat: 0-based beat during which rst_n is pulsed (-1 none).
  task automatic do_fill(input logic [31:0] addr, input int ar_wait, input int gap_pct,
                         input int err_beat, input int rlast_beat, input int rst_beat,
                         output int way_seen);
    logic [18:0] tag;
    logic [6:0]  idx;
    logic [31:0] line;
    int          exp_way;
    int          consumed;
    bit          exp_err;
    int          beat;
    int          cycles;
    bit          give;
    bit          aborted;

    tag      = addr[31:13];
    idx      = addr[12:6];
    line     = {addr[31:6], 6'b0};
    exp_way  = rr_model[idx];
    consumed = (rlast_beat >= 1 && rlast_beat <= 16) ? rlast_beat : 16;
    exp_err  = (err_beat >= 0 && err_beat < consumed) || (rlast_beat != 16);
    aborted  = 1'b0;
    way_seen = -1;

    @(negedge clk);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = addr;
    #1;
    chk("idle_miss_ready", 64'(bus.miss_ready), 64'd1);
    chk("idle_data_we",    64'(bus.data_we),    64'd0);

    @(negedge clk);
    bus.miss_valid = 1'b0;
    bus.miss_addr  = $urandom;
    for (int w = 0; w <= ar_wait; w++) begin
      if (w > 0) @(negedge clk);
      bus.arready = (w == ar_wait);
      #1;
      chk("ar_arvalid",    64'(bus.arvalid),    64'd1);
      chk("ar_araddr",     64'(bus.araddr),     64'(line));
      chk("ar_miss_ready", 64'(bus.miss_ready), 64'd0);
      chk("ar_rready",     64'(bus.rready),     64'd0);
      if (w == 0) begin
        chk("ar_arlen",   64'(bus.arlen),   64'd15);
        chk("ar_arsize",  64'(bus.arsize),  64'd2);
        chk("ar_arburst", 64'(bus.arburst), 64'd1);
      end
    end

    beat   = 0;
    cycles = 0;
    while (beat < consumed && cycles < 400 && !aborted) begin
      @(negedge clk);
      bus.arready = 1'b0;
      give        = ($urandom_range(99) >= gap_pct);
      bus.rvalid  = give;
      bus.rdata   = $urandom;
      bus.rresp   = (give && beat == err_beat) ? 2'b10 : 2'b00;
      bus.rlast   = give && (beat + 1 == rlast_beat);
      if (give && beat == rst_beat) begin
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        for (int s = 0; s < 128; s++) rr_model[s] = 0;
        aborted = 1'b1;
      end else begin
        #1;
        chk("rd_rready",     64'(bus.rready),     64'd1);
        chk("rd_miss_ready", 64'(bus.miss_ready), 64'd0);
        chk("rd_arvalid",    64'(bus.arvalid),    64'd0);
        chk("rd_fill_done",  64'(bus.fill_done),  64'd0);
        chk("rd_data_we",    64'(bus.data_we),    64'(give));
        if (give) begin
          chk("rd_data_word",  64'(bus.data_word),  64'(beat));
          chk("rd_data_wdata", 64'(bus.data_wdata), 64'(bus.rdata));
          chk("rd_data_index", 64'(bus.data_index), 64'(idx));
          chk("rd_data_way",   64'(bus.data_way),   64'(exp_way));
          beat++;
        end
        cycles++;
      end
    end
    if (!aborted && beat < consumed) chk("beat_timeout", 64'(beat), 64'(consumed));

    @(negedge clk);
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
    if (aborted) begin
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        #1;
        chk("postrst_tag_we",    64'(bus.tag_we),    64'd0);
        chk("postrst_fill_done", 64'(bus.fill_done), 64'd0);
        chk("postrst_data_we",   64'(bus.data_we),   64'd0);
        @(negedge clk);
      end
    end else begin
      #1;
      chk("cm_fill_done", 64'(bus.fill_done), 64'd1);
      chk("cm_fill_err",  64'(bus.fill_err),  64'(exp_err));
      chk("cm_tag_we",    64'(bus.tag_we),    64'(!exp_err));
      chk("cm_tag_new",   64'(bus.tag_new),   64'(tag));
      chk("cm_tag_index", 64'(bus.tag_index), 64'(idx));
      chk("cm_tag_way",   64'(bus.tag_way),   64'(exp_way));
      chk("cm_data_we",   64'(bus.data_we),   64'd0);
      chk("cm_rready",    64'(bus.rready),    64'd0);
      way_seen = int'(bus.tag_way);
      if (!exp_err) rr_model[idx] = (rr_model[idx] + 1) % 4;

      @(negedge clk);
      #1;
      chk("post_fill_done",  64'(bus.fill_done),  64'd0);
      chk("post_tag_we",     64'(bus.tag_we),     64'd0);
      chk("post_miss_ready", 64'(bus.miss_ready), 64'd1);
      chk("post_tag_new",    64'(bus.tag_new),    64'(tag));
    end
  endtask

  function automatic logic [31:0] addr_in_set(input logic [6:0] idx);
    logic [31:0] a;
    a       = $urandom;
    a[12:6] = idx;
    return a;
  endfunction

  initial begin
    int w;
    int exp_ways [5];
    logic [6:0] sets [3];

    exp_ways = '{0, 1, 2, 3, 0};
    sets     = '{7'h59, 7'h10, 7'h11};
    for (int s = 0; s < 128; s++) rr_model[s] = 0;

    rst_n          = 1'b0;
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    bus.arready    = 1'b0;
    bus.rvalid     = 1'b0;
    bus.rdata      = '0;
    bus.rresp      = 2'b00;
    bus.rlast      = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_rel_miss_ready", 64'(bus.miss_ready), 64'd1);
    chk("rst_rel_arvalid",    64'(bus.arvalid),    64'd0);

    // Directed line fill and round-robin walk through set 0x59
    do_fill(32'h1234_5678, 0, 0, -1, 16, -1, w);
    chk("rr_way_0", 64'(w), 64'(exp_ways[0]));
    for (int k = 1; k < 5; k++) begin
      do_fill(addr_in_set(7'h59), 0, 0, -1, 16, -1, w);
      chk($sformatf("rr_way_%0d", k), 64'(w), 64'(exp_ways[k]));
    end

    // SLVERR mid-burst: full burst consumed, no tag write, way reused
    do_fill(addr_in_set(7'h59), 0, 0, 7, 16, -1, w);
    chk("err_way", 64'(w), 64'd1);
    do_fill(addr_in_set(7'h59), 0, 0, -1, 16, -1, w);
    chk("err_reuse_way", 64'(w), 64'd1);

    // Stalled AR and gappy R
    do_fill(addr_in_set(7'h22), 5, 40, -1, 16, -1, w);

    // Early rlast, and missing rlast
    do_fill(addr_in_set(7'h22), 0, 20, -1, 10, -1, w);
    do_fill(addr_in_set(7'h22), 1, 20, -1, 0, -1, w);

    // Reset during beat 5, then any set starts over at way 0
    do_fill(addr_in_set(7'h59), 0, 0, -1, 16, 5, w);
    do_fill(addr_in_set(7'h33), 0, 0, -1, 16, -1, w);
    chk("after_rst_way", 64'(w), 64'd0);
    do_fill(addr_in_set(7'h59), 0, 0, -1, 16, -1, w);
    chk("after_rst_way_59", 64'(w), 64'd0);

    // Random mix over a few sets
    for (int n = 0; n < 30; n++) begin
      int eb, rl;
      eb = ($urandom_range(99) < 25) ? int'($urandom_range(15)) : -1;
      rl = ($urandom_range(99) < 25) ? int'($urandom_range(15)) : 16;
      do_fill(addr_in_set(sets[$urandom_range(2)]), int'($urandom_range(3)),
              int'($urandom_range(50)), eb, rl, -1, w);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Cache refill controller: on a miss, selects a victim way for the set, fetches the 64-byte line with one AXI4 INCR read burst, and streams each beat into the data array. After a clean burst it writes the new tag through the tag store write port. It sits between the miss detector and the AXI master port, and is the only writer of the tag store.

## Interface

Parameters:
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, AXI read data width; 16 beats per line
- `TAG_W`, 19, tag width (`addr[31:13]`)
- `INDEX_W`, 7, set index width (`addr[12:6]`), 128 sets
- `OFFSET_W`, 6, line offset width, 64-byte lines

Ports:
- `clk` in 1, single clock
- `rst_n` in 1, asynchronous active-low reset
- `miss_valid` in 1, refill request
- `miss_ready` out 1, request accepted when both high
- `miss_addr` in 32, miss byte address
- `arvalid` out 1, AXI AR valid
- `arready` in 1, AXI AR ready
- `araddr` out 32, line-aligned address
- `arlen` out 8, constant 15
- `arsize` out 3, constant 3'b010
- `arburst` out 2, constant 2'b01 (INCR)
- `rvalid` in 1, AXI R valid
- `rready` out 1, AXI R ready
- `rdata` in 32, read data
- `rresp` in 2, read response
- `rlast` in 1, last beat
- `data_we` out 1, data array word write
- `data_index` out 7, set
- `data_way` out 2, way
- `data_word` out 4, word within line
- `data_wdata` out 32, equals `rdata`
- `tag_we` out 1, tag store write enable
- `tag_index` out 7, set
- `tag_way` out 2, way
- `tag_new` out 19, tag value
- `fill_done` out 1, one-cycle completion pulse
- `fill_err` out 1, qualifies `fill_done`; 1 means the fill failed

## Operation

- States and transitions:
  - IDLE: `miss_ready`=1. When `miss_valid` is high, capture tag, index and victim = `rr[index]`; go to AR.
  - AR: `arvalid`=1, `araddr`={tag, index, 6'b0}. On `arready`, go to RDATA.
  - RDATA: `rready`=1. Each `rvalid` beat:
    - `data_we`=1 combinationally; `data_word`=beat count; count increments.
    - `rresp`≠2'b00 sets the sticky err flag.
  - Burst ends on the first of: the `rlast` beat, or the 16th beat. Err is set unless `rlast` coincides with the 16th beat. Then go to COMMIT.
  - COMMIT, one cycle:
    - `fill_done`=1, `fill_err`=err.
    - If err=0: `tag_we`=1 and `rr[index]` increments mod 4 (wraps 3→0).
    - If err=1: no tag write and `rr` is unchanged.
    - Return to IDLE; beat count and err clear.
- Victim policy: per-set 2-bit round-robin counter, 128 entries, all 0 at reset.
- `tag_*` and `data_index`/`data_way` are driven from captured registers; they hold between fills.
- `miss_ready`=0 outside IDLE; there is only one outstanding fill.
- `data_we` never asserts outside RDATA.

## Timing

- Reset (async assert, sync release):
  - state IDLE; `miss_ready`=1.
  - `arvalid`, `rready`, `data_we`, `tag_we`, `fill_done`, `fill_err` = 0.
  - `araddr`, `tag_*`, `data_*` = 0; all `rr` = 0.
- Miss accepted in cycle T → `arvalid` high in T+1.
- `arvalid` and `araddr` are stable until `arready`.
- `rready` is high in the cycle after the AR handshake.
- Data write occurs in the same cycle as its R handshake (zero latency).
- COMMIT is the cycle after the final beat. The next miss can be accepted the cycle after COMMIT.
- Minimum fill with no wait states: 1 AR + 16 R + 1 COMMIT = 18 cycles from acceptance.
- Reset during any state aborts the fill: no `tag_we`, no `fill_done`.

## Test plan

- Refill for `miss_addr`=0x1234_5678, zero-wait slave:
  - AR: `araddr`=0x1234_5640, `arlen`=15.
  - 16 `data_we` pulses, words 0..15, index 0x59, way 0.
  - COMMIT: `tag_we` with `tag_new`=0x091A2, `tag_index`=0x59, `tag_way`=0; `fill_done`=1, `fill_err`=0.
- Five successive clean misses to index 0x59 → victim ways 0, 1, 2, 3, 0.
- `rresp`=2'b10 on beat 7 → all 16 beats still consumed, no `tag_we`, `fill_err`=1. The next miss to the same set reuses the same way.
- `arready` held low for 5 cycles, then random `rvalid` gaps → `arvalid`/`araddr` stable, `miss_ready`=0 throughout, `data_word` sequence 0..15 with no duplicates or skips.
- `rlast` on beat 10 → COMMIT follows beat 10, `fill_err`=1, no `tag_we`. No `rlast` on beat 16 → burst ends, `fill_err`=1.
- `rst_n` pulsed low during beat 5 → all outputs at reset values immediately, no `tag_we`. The next miss to any set uses way 0.
